// File: rtl/tune_sequencer.sv
// Melody player: walks a note ROM (beats + period per word) and drives the tone PWM
// period/enable, with start/stop, looping and a silent articulation gap before each note ends.
module tune_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int BEAT_CYC = 12_500_000,
  parameter int GAP_CYC  = 500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [19:0]       pwm_parameter,
  output logic              pwm_en,
  output logic              busy,
  output logic              done
);

  localparam int             CW       = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam logic [CW-1:0]  CYC_LAST = CW'(BEAT_CYC - 1);
  localparam logic [CW-1:0]  CYC_GAP  = CW'(BEAT_CYC - 1 - GAP_CYC);
  localparam bit             HAS_GAP  = (GAP_CYC != 0);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [19:0]       param_d;
  logic              en_d, done_d;
  logic [3:0]        beat_cnt, beat_d;
  logic [CW-1:0]     cyc_cnt, cyc_d;

  logic [3:0]  rom_beats;
  logic [19:0] rom_period;
  logic        last_beat;

  assign rom_beats  = rom_data[23:20];
  assign rom_period = rom_data[19:0];
  assign last_beat  = (beat_cnt == 4'd1);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rom_addr      <= '0;
      pwm_parameter <= '0;
      pwm_en        <= 1'b0;
      done          <= 1'b0;
      beat_cnt      <= '0;
      cyc_cnt       <= '0;
    end else begin
      state         <= state_d;
      rom_addr      <= addr_d;
      pwm_parameter <= param_d;
      pwm_en        <= en_d;
      done          <= done_d;
      beat_cnt      <= beat_d;
      cyc_cnt       <= cyc_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = rom_addr;
    param_d = pwm_parameter;
    en_d    = pwm_en;
    done_d  = 1'b0;
    beat_d  = beat_cnt;
    cyc_d   = cyc_cnt;
    case (state)
      S_IDLE: begin
        en_d = 1'b0;
        if (start) begin
          addr_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        en_d    = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (rom_beats == 4'd0) begin
          if (loop) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          param_d = rom_period;
          beat_d  = rom_beats;
          cyc_d   = '0;
          en_d    = (rom_period != 20'd0);
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // Gap drops the enable early on the last beat; period stays put until next LOAD.
        if (HAS_GAP && last_beat && cyc_cnt == CYC_GAP)
          en_d = 1'b0;
        if (cyc_cnt == CYC_LAST) begin
          cyc_d = '0;
          if (last_beat) begin
            addr_d  = rom_addr + ADDR_W'(1);
            en_d    = 1'b0;
            state_d = S_FETCH;
          end else begin
            beat_d = beat_cnt - 4'd1;
          end
        end else begin
          cyc_d = cyc_cnt + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = rom_addr;
      param_d = pwm_parameter;
      en_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer: expected output waveforms are scheduled from the ROM contents
// and stimulus pulses, then compared cycle by cycle against the DUT.
module tb_tune_sequencer;
  localparam int AW = 4, BC = 10, GC = 2, MAXC = 1024;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data;
  logic [19:0]   pwm_parameter;
  logic          pwm_en, busy, done;

  tune_sequencer #(.ADDR_W(AW), .BEAT_CYC(BC), .GAP_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .pwm_parameter(pwm_parameter),
    .pwm_en(pwm_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [16];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_vec = 0, n_bad = 0;
  bit st [MAXC], sp [MAXC], rs [MAXC];
  bit e_en [MAXC], e_busy [MAXC], e_done [MAXC];
  int e_par [MAXC], e_addr [MAXC];
  int n100, n200, n50, n0on, n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_exp(input int t, input bit b, input bit en, input bit dn, input int par, input int a);
    e_busy[t] = b; e_en[t] = en; e_done[t] = dn; e_par[t] = par; e_addr[t] = a;
  endtask

  task automatic fill_idle(input int from, input int len, input int par, input int a);
    for (int t = from; t < len; t++) set_exp(t, 0, 0, 0, par, a);
  endtask

  // Song played from a start accepted in cycle c: fetch, load, then beats*BC cycles per note.
  task automatic play(input int c, input int len);
    int t, a, par, b, p;
    t = c + 1; a = 0; par = e_par[c];
    while (t < len) begin
      set_exp(t, 1, 0, 0, par, a);
      t++;
      if (t >= len) break;
      set_exp(t, 1, 0, 0, par, a);
      b = int'(rom[a][23:20]);
      p = int'(rom[a][19:0]);
      t++;
      if (b == 0) begin
        if (loop) begin
          a = 0;
          continue;
        end
        fill_idle(t, len, par, a);
        if (t < len) e_done[t] = 1;
        return;
      end
      par = p;
      for (int k = 0; k < b * BC; k++)
        if (t + k < len) set_exp(t + k, 1, (p != 0) && (k < b * BC - GC), 0, par, a);
      t += b * BC;
      a = (a + 1) % 16;
    end
  endtask

  task automatic model(input int len);
    fill_idle(0, len, 0, 0);
    for (int c = 0; c < len; c++) begin
      if (rs[c])                    fill_idle(c + 1, len, 0, 0);
      else if (sp[c])               fill_idle(c + 1, len, e_par[c], e_addr[c]);
      else if (st[c] && !e_busy[c]) play(c, len);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < MAXC; c++) begin st[c] = 0; sp[c] = 0; rs[c] = 0; end
    for (int i = 0; i < 16; i++) rom[i] = 24'h0;
    rs[0] = 1;
  endtask

  task automatic run(input int len);
    model(len);
    n100 = 0; n200 = 0; n50 = 0; n0on = 0; n_done = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk($sformatf("en@%0d", c),   pwm_en,        e_en[c]);
        chk($sformatf("par@%0d", c),  pwm_parameter, e_par[c]);
        chk($sformatf("addr@%0d", c), rom_addr,      e_addr[c]);
        chk($sformatf("busy@%0d", c), busy,          e_busy[c]);
        chk($sformatf("done@%0d", c), done,          e_done[c]);
        if (pwm_en && pwm_parameter == 20'd100) n100++;
        if (pwm_en && pwm_parameter == 20'd200) n200++;
        if (pwm_en && pwm_parameter == 20'd50)  n50++;
        if (pwm_en && pwm_parameter == 20'd0)   n0on++;
        if (done) n_done++;
      end
      rst_n = !rs[c];
      start = st[c];
      stop  = sp[c];
    end
  endtask

  initial begin
    // Two-note song, no loop
    clr(); loop = 0;
    rom[0] = {4'd2, 20'd100}; rom[1] = {4'd1, 20'd200};
    st[2] = 1;
    run(60);
    chk("song_p100_on", n100, 18);
    chk("song_p200_on", n200, 8);
    chk("song_done",    n_done, 1);

    // Leading rest
    clr(); loop = 0;
    rom[0] = {4'd1, 20'd0}; rom[1] = {4'd1, 20'd50};
    st[2] = 1;
    run(50);
    chk("rest_on",    n0on, 0);
    chk("rest_p50",   n50, 8);
    chk("rest_done",  n_done, 1);

    // Looping song
    clr(); loop = 1;
    rom[0] = {4'd2, 20'd100}; rom[1] = {4'd1, 20'd200};
    st[2] = 1;
    run(150);
    chk("loop_replay", n100 >= 36, 1);
    chk("loop_done",   n_done, 0);

    // Stop mid-note, restart five cycles later
    clr(); loop = 0;
    rom[0] = {4'd3, 20'd300}; rom[1] = {4'd2, 20'd400};
    st[2] = 1; sp[20] = 1; st[25] = 1;
    run(120);
    chk("stop_done", n_done, 1);

    // Start while busy, start+stop together while idle
    clr(); loop = 0;
    rom[0] = {4'd1, 20'd77};
    st[2] = 1; st[6] = 1; st[10] = 1; st[30] = 1; sp[30] = 1;
    run(60);
    chk("ignore_done", n_done, 1);

    // Reset during PLAY, then a clean replay
    clr(); loop = 0;
    rom[0] = {4'd3, 20'd500};
    st[2] = 1; rs[15] = 1; st[20] = 1;
    run(70);

    // Sixteen notes, address wraps and keeps playing
    clr(); loop = 0;
    for (int i = 0; i < 16; i++) rom[i] = {4'd1, 20'(10 * (i + 1))};
    st[2] = 1;
    run(240);
    chk("wrap_done", n_done, 0);

    // Random ROMs and control pulses
    for (int s = 0; s < 12; s++) begin
      clr();
      loop = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        int b, p;
        b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
        p = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20'hFFFFF));
        rom[i] = {4'(b), 20'(p)};
      end
      st[2] = 1;
      for (int c = 3; c < 298; c++) begin
        st[c] = ($urandom_range(0, 29) == 0);
        sp[c] = ($urandom_range(0, 99) == 0);
        rs[c] = ($urandom_range(0, 299) == 0);
      end
      run(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
